// File: rtl/camera_capture_pkg.sv
// Shared constants and FSM state type for the OV7670 capture front-end.
package camera_capture_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W       = 20;
    localparam int Y_PHASE      = 1;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        IDLE_LINE = 2'd1,
        LINE      = 2'd2
    } capState_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer bringing a camera pin into the system clock domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/camera_capture.sv
// OV7670 capture: extracts the luma byte of each YUV422 pair and writes whole frames to RAM.
// Define CAPTURE_STATS_EN to add the frame_count / line_err status outputs.
module camera_capture
    import camera_capture_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic              pclk,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] pos_pxl,
    output logic [7:0]        pix_out,
    output logic              frame_done
`ifdef CAPTURE_STATS_EN
    ,
    output logic [7:0]        frame_count,
    output logic              line_err
`endif
);

    logic vsS, hrefS, pclkS;

    sync_2ff uSyncVs   (.clk(clk), .reset(reset), .d_i(vsync), .q_o(vsS));
    sync_2ff uSyncHref (.clk(clk), .reset(reset), .d_i(href),  .q_o(hrefS));
    sync_2ff uSyncPclk (.clk(clk), .reset(reset), .d_i(pclk),  .q_o(pclkS));

    logic [7:0] data1_q, data2_q;
    logic       vsPrev_q, hrefPrev_q, pclkPrev_q;
    logic       pclkRise_q, hrefFall_q, vsRise_q, vsFall_q;

    // Data takes the same two-stage path as pclk; edge pulses are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data1_q    <= '0;
            data2_q    <= '0;
            vsPrev_q   <= 1'b0;
            hrefPrev_q <= 1'b0;
            pclkPrev_q <= 1'b0;
            pclkRise_q <= 1'b0;
            hrefFall_q <= 1'b0;
            vsRise_q   <= 1'b0;
            vsFall_q   <= 1'b0;
        end else begin
            data1_q    <= data;
            data2_q    <= data1_q;
            vsPrev_q   <= vsS;
            hrefPrev_q <= hrefS;
            pclkPrev_q <= pclkS;
            pclkRise_q <= pclkS & ~pclkPrev_q;
            hrefFall_q <= ~hrefS & hrefPrev_q;
            vsRise_q   <= vsS & ~vsPrev_q;
            vsFall_q   <= ~vsS & vsPrev_q;
        end
    end

    capState_e         state_q;
    logic [9:0]        x_q;
    logic [8:0]        y_q;
    logic [ADDR_W-1:0] addr_q, lineBase_q;
    logic              phase_q;
    logic              we_q, frameDone_q;
    logic [ADDR_W-1:0] pos_q;
    logic [7:0]        pix_q;
    logic [ADDR_W-1:0] nextBase_d;
    logic [8:0]        yInc_d, yEnd_d;
    logic              lineClose_d;

    // y saturates so an over-long frame cannot wrap back into valid rows.
    always_comb begin
        nextBase_d  = lineBase_q + ADDR_W'(H_ACTIVE);
        yInc_d      = (y_q == '1) ? y_q : y_q + 9'd1;
        lineClose_d = (state_q == LINE) && hrefFall_q && (x_q != '0);
        yEnd_d      = lineClose_d ? yInc_d : y_q;
    end

`ifdef CAPTURE_STATS_EN
    logic [7:0] frameCount_q;
    logic       lineErr_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            lineBase_q  <= '0;
            phase_q     <= 1'b0;
            we_q        <= 1'b0;
            frameDone_q <= 1'b0;
            pos_q       <= '0;
            pix_q       <= '0;
`ifdef CAPTURE_STATS_EN
            frameCount_q <= '0;
            lineErr_q    <= 1'b0;
`endif
        end else begin
            we_q        <= 1'b0;
            frameDone_q <= 1'b0;
            case (state_q)
                WAIT_SYNC: begin
                    if (vsFall_q) begin
                        state_q    <= IDLE_LINE;
                        x_q        <= '0;
                        y_q        <= '0;
                        addr_q     <= '0;
                        lineBase_q <= '0;
                    end
                end
                IDLE_LINE: begin
                    if (hrefPrev_q) begin
                        state_q <= LINE;
                        phase_q <= 1'b0;
                    end
                end
                LINE: begin
                    if (hrefFall_q) begin
                        state_q <= IDLE_LINE;
                        x_q     <= '0;
                        if (x_q != '0) begin
                            y_q        <= yInc_d;
                            lineBase_q <= nextBase_d;
                            addr_q     <= nextBase_d;
                        end
`ifdef CAPTURE_STATS_EN
                        if ((x_q != '0) && (x_q != 10'(H_ACTIVE)))
                            lineErr_q <= 1'b1;
`endif
                    end else if (pclkRise_q) begin
                        phase_q <= ~phase_q;
                        if ((phase_q == 1'(Y_PHASE)) && (x_q < 10'(H_ACTIVE)) && (y_q < 9'(V_ACTIVE))) begin
                            pix_q  <= data2_q;
                            pos_q  <= addr_q;
                            we_q   <= 1'b1;
                            addr_q <= addr_q + 1'b1;
                            x_q    <= x_q + 10'd1;
                        end
                    end
                end
                default: state_q <= WAIT_SYNC;
            endcase
            // Frame end overrides the line handling above but keeps its line close.
            if (vsRise_q && (state_q == IDLE_LINE || state_q == LINE)) begin
                state_q     <= WAIT_SYNC;
                frameDone_q <= 1'b1;
`ifdef CAPTURE_STATS_EN
                frameCount_q <= frameCount_q + 8'd1;
                if (yEnd_d != 9'(V_ACTIVE))
                    lineErr_q <= 1'b1;
`endif
            end
        end
    end

    assign we         = we_q;
    assign pos_pxl    = pos_q;
    assign pix_out    = pix_q;
    assign frame_done = frameDone_q;
`ifdef CAPTURE_STATS_EN
    assign frame_count = frameCount_q;
    assign line_err    = lineErr_q;
`endif

endmodule

// File: doc/camera_capture.md
# camera_capture

Capture front-end between the OV7670 camera pins and the dual-port frame RAM. Samples the camera pixel bus (pclk, href, vsync, 8-bit data) in the system clock domain and extracts the luma byte of each YUV422 pixel pair. Produces a one-cycle write strobe, a linear frame address (y·640 + x) and the pixel byte for the RAM write port. Only whole frames are written: capture starts at a vsync falling edge and ends at the next vsync rising edge.

## Interface
- H_ACTIVE, 640, pixels per line written to memory
- V_ACTIVE, 480, lines per frame written to memory
- ADDR_W, 20, width of pos_pxl
- Y_PHASE, 1, byte index (0/1) within each pixel pair that carries luma

- clk  in  1  system clock (50 MHz); one clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- vsync  in  1  camera vsync, asynchronous; high = vertical blanking
- href  in  1  camera href, asynchronous; high = active line
- pclk  in  1  camera pixel clock, asynchronous, ≤12.5 MHz
- data  in  8  camera data bus, valid at pclk rising edge
- we  out  1  RAM write strobe, one clk wide per pixel
- pos_pxl  out  ADDR_W  RAM write address, valid while we=1
- pix_out  out  8  luma byte, valid while we=1
- frame_done  out  1  one-cycle pulse at end of each captured frame

## Operation
- vsync, href, pclk each pass a 2-flop synchronizer; data passes an equal-depth 2-stage register so it stays aligned with synchronized pclk.
- Edge detect on synchronized signals: pclk_rise, href_fall, vs_rise, vs_fall (one-cycle pulses).
- FSM states: WAIT_SYNC, IDLE_LINE, LINE.
  - WAIT_SYNC: entered after reset and after frame end; nothing written; vs_fall → IDLE_LINE, clear x, y, addr, line_base.
  - IDLE_LINE: synchronized href high → LINE, phase=0.
  - LINE: each pclk_rise toggles phase. When phase==Y_PHASE and x<H_ACTIVE and y<V_ACTIVE: register pix_out=data, pos_pxl=addr, we=1; addr++, x++. Bytes with x≥H_ACTIVE or y≥V_ACTIVE are dropped (no we). href_fall → IDLE_LINE; if x>0: y++, line_base += H_ACTIVE, addr = line_base + H_ACTIVE; x=0.
  - vs_rise in IDLE_LINE or LINE → WAIT_SYNC, frame_done=1 for one cycle.
- Address generation incremental only (no multiplier); short lines skip their unwritten tail, next line always starts at y·H_ACTIVE.
- Arithmetic: x 10 bits, y 9 bits, addr/line_base ADDR_W bits; max address H_ACTIVE·V_ACTIVE−1 = 307199.
- Simultaneous href_fall and vs_rise: line closes, then frame ends; frame_done still pulses.
- Reset mid-frame: outputs to 0, FSM to WAIT_SYNC; partial frame abandoned, next write only after a fresh vs_fall.

## Timing
- Reset values: we=0, pos_pxl=0, pix_out=0, frame_done=0 (and STATS outputs 0).
- Latency: we asserted on the 4th clk rising edge after pclk rise is first sampled (2 sync + 1 edge + 1 output register).
- we never high two consecutive cycles; pos_pxl/pix_out hold value until next write.
- Input requirement: pclk high and low each ≥2 clk periods; data stable ≥3 clk periods around pclk rise.
- frame_done pulses 3 clk cycles after vsync rise is first sampled.

## Configuration
- CAPTURE_STATS_EN defined: extra outputs frame_count (8 bits, increments with each frame_done, wraps 255→0) and line_err (1 bit, sticky, set when a line closes with 0<x≠H_ACTIVE or when a frame ends with y≠V_ACTIVE; cleared only by reset).
- Undefined: ports and logic absent; capture behaviour identical.

## Structure
- Package camera_capture_pkg: H_ACTIVE, V_ACTIVE, FRAME_PIXELS (307200) constants and FSM state enum (WAIT_SYNC, IDLE_LINE, LINE).
- Sub-module sync_2ff: single-bit 2-flop synchronizer with async active-high reset, instanced for vsync, href, pclk.

## Test plan
- Reset released mid-frame (vsync low, href toggling) → no we until after next vsync fall; first write at pos_pxl=0.
- Full 640×480 frame, Y_PHASE=1, data = pixel-pair counter → exactly 307200 we pulses, pos_pxl 0..307199 contiguous, pix_out equals every second byte, one frame_done.
- Line of 700 pixels → writes stop at x=639; next line starts at pos_pxl=640.
- Line of 600 pixels → next line first write at pos_pxl=640; with CAPTURE_STATS_EN line_err=1.
- Two frames back to back → frame_count 0→1→2; second frame restarts at pos_pxl=0.
- pclk at 12.5 MHz, random phase vs clk → every pixel written once, we never two cycles in a row.
